morse_tx_engine: RTL and testbench

MORSE_TX_ENGINE -- requirements
Module: morse_tx_engine

---
 rtl/morse_tx_engine_pkg.sv | 34 +++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/morse_tx_engine.sv | 144 ++++++++++++++
 tb/tb_morse_tx_engine.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_tx_engine_pkg.sv
// rtl/morse_tx_engine_pkg.sv - shared encodings for the Morse transmit engine
// Code word layout: [7:5] element count, [4:0] pattern with bit0 sent first, 1 = dash.
package morse_tx_engine_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_MARK  = 3'd2,
      S_SPACE = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   localparam logic [7:0] ETX_CODE        = 8'h03;
   localparam logic [7:0] WORD_SPACE_CODE = 8'h00;

   localparam int COUNT_MSB = 7;
   localparam int COUNT_LSB = 5;
   localparam int PAT_MSB   = 4;
   localparam int PAT_LSB   = 0;

   function automatic logic [2:0] code_count(input logic [7:0] code);
      return code[COUNT_MSB:COUNT_LSB];
   endfunction

   function automatic logic [4:0] code_pattern(input logic [7:0] code);
      return code[PAT_MSB:PAT_LSB];
   endfunction

   // A character carries 1..5 elements; other non-control codes are dropped.
   function automatic logic code_is_char(input logic [7:0] code);
      return (code_count(code) != 3'd0) && (code_count(code) <= 3'd5);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with flush and registered occupancy
// A full FIFO refuses a push even when a pop happens in the same cycle.
module sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       wr_data,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == FULL_LVL);
   assign empty   = (level == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   // Pointers are exactly AW bits wide, so they wrap at DEPTH on their own.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/morse_tx_engine.sv
// rtl/morse_tx_engine.sv - keys queued Morse code words onto a line with unit timing
// Unit length is latched at start; each timed state runs (units+1) * unit_len clocks.
module morse_tx_engine
   import morse_tx_engine_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             wr_data,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [CNT_W-1:0]       bit_time,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   line_invert,
   output logic                   out,
   output logic                   busy,
   output logic                   done,
   output logic [$clog2(DEPTH):0] level
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] unit_len;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       units;
   logic [4:0]       pat;
   logic [2:0]       elems;
   logic             line;
   logic             done_q;
   logic [7:0]       head;
   logic             full;
   logic             empty;
   logic             unit_end;

   assign wr_ready = !full;
   assign busy     = (state != S_IDLE);
   assign done     = done_q;
   assign out      = line ^ line_invert;
   assign unit_end = (cnt == '0) && (units == 2'd0);

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (wr_valid && !abort),
      .pop     ((state == S_LOAD) && !abort),
      .flush   (abort),
      .wr_data (wr_data),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .level   (level)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         unit_len <= CNT_ONE;
         cnt      <= '0;
         units    <= 2'd0;
         pat      <= 5'd0;
         elems    <= 3'd0;
         line     <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort) begin
            state <= S_IDLE;
            line  <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start && !empty) begin
                     state    <= S_LOAD;
                     unit_len <= (bit_time == '0) ? CNT_ONE : bit_time;
                  end
               end
               S_LOAD: begin
                  if (head == ETX_CODE) begin
                     state  <= S_IDLE;
                     done_q <= 1'b1;
                  end else if (head == WORD_SPACE_CODE) begin
                     state <= S_GAP;
                     cnt   <= unit_len - CNT_ONE;
                     units <= 2'd3;
                  end else if (code_is_char(head)) begin
                     state <= S_MARK;
                     line  <= 1'b1;
                     pat   <= code_pattern(head);
                     elems <= code_count(head);
                     cnt   <= unit_len - CNT_ONE;
                     units <= code_pattern(head)[0] ? 2'd2 : 2'd0;
                  end else if (level > LW'(1)) begin
                     state <= S_LOAD;
                  end else begin
                     state  <= S_IDLE;
                     done_q <= 1'b1;
                  end
               end
               S_MARK, S_SPACE, S_GAP: begin
                  if (!unit_end) begin
                     if (cnt == '0) begin
                        cnt   <= unit_len - CNT_ONE;
                        units <= units - 2'd1;
                     end else begin
                        cnt <= cnt - CNT_ONE;
                     end
                  end else if (state == S_MARK) begin
                     // Last element gets the 3-unit inter-character gap.
                     state <= S_SPACE;
                     line  <= 1'b0;
                     cnt   <= unit_len - CNT_ONE;
                     units <= (elems > 3'd1) ? 2'd0 : 2'd2;
                     pat   <= pat >> 1;
                     elems <= elems - 3'd1;
                  end else if (state == S_SPACE && elems != 3'd0) begin
                     state <= S_MARK;
                     line  <= 1'b1;
                     cnt   <= unit_len - CNT_ONE;
                     units <= pat[0] ? 2'd2 : 2'd0;
                  end else if (!empty) begin
                     state <= S_LOAD;
                  end else begin
                     state  <= S_IDLE;
                     done_q <= 1'b1;
                  end
               end
               default: begin
                  state <= S_IDLE;
                  line  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_morse_tx_engine.sv
// tb/tb_morse_tx_engine.sv - self-checking bench for morse_tx_engine
// Expected line waveforms come from the timing rules applied to the list of words.
module tb_morse_tx_engine;

   localparam int DEPTH = 8;
   localparam int CNT_W = 16;
   localparam int LW    = $clog2(DEPTH) + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [7:0]       wr_data = 8'h00;
   logic             wr_valid = 1'b0;
   logic             wr_ready;
   logic [CNT_W-1:0] bit_time = '0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic             line_invert = 1'b0;
   logic             out;
   logic             busy;
   logic             done;
   logic [LW-1:0]    level;

   int checks = 0;
   int failures = 0;

   logic [7:0] late_q[$];
   bit         exp_q[$];
   logic       cap_out[$];
   logic       cap_busy[$];
   logic       cap_done[$];

   morse_tx_engine #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_data     (wr_data),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .bit_time    (bit_time),
      .start       (start),
      .abort       (abort),
      .line_invert (line_invert),
      .out         (out),
      .busy        (busy),
      .done        (done),
      .level       (level)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Line level per clock from the first LOAD clock until the final state ends.
   function automatic void build_exp(input logic [7:0] words[$], input int bt);
      int u;
      int c;
      logic [7:0] w;
      exp_q.delete();
      u = (bt == 0) ? 1 : bt;
      for (int k = 0; k < words.size(); k++) begin
         w = words[k];
         exp_q.push_back(1'b0);
         if (w == 8'h03) break;
         c = int'(w[7:5]);
         if (w == 8'h00) begin
            repeat (4 * u) exp_q.push_back(1'b0);
         end else if (c >= 1 && c <= 5) begin
            for (int e = 0; e < c; e++) begin
               repeat ((w[e] ? 3 : 1) * u) exp_q.push_back(1'b1);
               repeat (((e == c - 1) ? 3 : 1) * u) exp_q.push_back(1'b0);
            end
         end
      end
   endfunction

   function automatic int first_wave_error(input logic inv);
      for (int i = 0; i < exp_q.size(); i++)
         if (cap_out[i] !== (exp_q[i] ^ inv) || cap_busy[i] !== 1'b1 || cap_done[i] !== 1'b0)
            return i;
      return -1;
   endfunction

   function automatic logic [7:0] rand_word();
      int k;
      logic [4:0] p;
      k = $urandom_range(0, 9);
      p = 5'($urandom);
      if (k == 0) return 8'h00;
      if (k == 1) return {3'($urandom_range(6, 7)), p};
      if (k == 2) return (p == 5'd0 || p == 5'd3) ? 8'h11 : {3'd0, p};
      return {3'($urandom_range(1, 5)), p};
   endfunction

   task automatic push_word(input logic [7:0] w);
      wr_valid = 1'b1;
      wr_data  = w;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   // Pulses start, then records n+2 clocks; late_q words are pushed from clock 1 on.
   task automatic capture(input int n);
      cap_out.delete();
      cap_busy.delete();
      cap_done.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < n + 2; i++) begin
         cap_out.push_back(out);
         cap_busy.push_back(busy);
         cap_done.push_back(done);
         if (i >= 1) begin
            if (late_q.size() != 0) begin
               wr_valid = 1'b1;
               wr_data  = late_q.pop_front();
            end else begin
               wr_valid = 1'b0;
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, out, wr_ready} !== 4'b0001 || level !== '0) begin
         failures++;
         $display("FAIL reset_state busy=%b done=%b out=%b wr_ready=%b level=%0d, expected 0 0 0 1 0",
                  busy, done, out, wr_ready, level);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, done, out, wr_ready} !== 4'b0001 || level !== '0) begin
         failures++;
         $display("FAIL reset_release busy=%b done=%b out=%b wr_ready=%b level=%0d, expected 0 0 0 1 0",
                  busy, done, out, wr_ready, level);
      end
   endtask

   task automatic test_letter_e();
      logic [9:0] e_pat;
      int bad;
      e_pat = 10'b0000000110;
      bit_time = 16'd2;
      line_invert = 1'b0;
      push_word(8'h20);
      push_word(8'h03);
      capture(10);
      bad = -1;
      for (int i = 0; i < 10; i++)
         if (bad < 0 && (cap_out[i] !== e_pat[i] || cap_busy[i] !== 1'b1)) bad = i;
      checks++;
      if (bad >= 0) begin
         failures++;
         $display("FAIL e_wave clock t%0d out=%b busy=%b, expected out=%b busy=1",
                  bad + 1, cap_out[bad], cap_busy[bad], e_pat[bad]);
      end
      checks++;
      if (cap_done[10] !== 1'b1 || cap_busy[10] !== 1'b0) begin
         failures++;
         $display("FAIL e_done t11 done=%b busy=%b, expected done=1 busy=0", cap_done[10], cap_busy[10]);
      end
      checks++;
      if (cap_done[11] !== 1'b0) begin
         failures++;
         $display("FAIL e_done_pulse t12 done=%b, expected 0", cap_done[11]);
      end
   endtask

   task automatic test_sequence_a_t();
      logic [7:0] wq[$];
      logic [8:0] a_pat;
      int bad;
      int n;
      wq = '{8'h42, 8'h00, 8'h21, 8'h03};
      a_pat = 9'b000111010;
      bit_time = 16'd1;
      line_invert = 1'b0;
      foreach (wq[k]) push_word(wq[k]);
      build_exp(wq, 1);
      n = exp_q.size();
      capture(n);
      bad = first_wave_error(1'b0);
      checks++;
      if (bad >= 0) begin
         failures++;
         $display("FAIL at_wave clock %0d out=%b busy=%b done=%b, expected out=%b busy=1 done=0",
                  bad, cap_out[bad], cap_busy[bad], cap_done[bad], exp_q[bad]);
      end
      bad = -1;
      for (int i = 0; i < 9; i++)
         if (bad < 0 && cap_out[i] !== a_pat[i]) bad = i;
      checks++;
      if (bad >= 0) begin
         failures++;
         $display("FAIL a_prefix clock %0d out=%b, expected %b", bad, cap_out[bad], a_pat[bad]);
      end
      checks++;
      if (cap_done[22] !== 1'b1 || cap_busy[22] !== 1'b0) begin
         failures++;
         $display("FAIL at_done clock 22 done=%b busy=%b, expected done=1 busy=0", cap_done[22], cap_busy[22]);
      end
   endtask

   task automatic test_random();
      logic [7:0] words[$];
      logic [7:0] all_w[$];
      logic [7:0] w;
      int bt;
      int n;
      int nl;
      int bad;
      logic inv;
      for (int iter = 0; iter < 12; iter++) begin
         words.delete();
         late_q.delete();
         all_w.delete();
         bt  = $urandom_range(0, 3);
         inv = 1'($urandom_range(0, 1));
         n   = $urandom_range(1, 5);
         words.push_back({3'($urandom_range(1, 5)), 5'($urandom)});
         for (int k = 1; k < n; k++) words.push_back(rand_word());
         nl = $urandom_range(0, 2);
         for (int k = 0; k < nl; k++) late_q.push_back(rand_word());
         if ($urandom_range(0, 1) == 1) begin
            if (nl != 0) late_q.push_back(8'h03);
            else words.push_back(8'h03);
         end
         foreach (words[k]) all_w.push_back(words[k]);
         foreach (late_q[k]) all_w.push_back(late_q[k]);
         line_invert = inv;
         bit_time = CNT_W'(bt);
         foreach (words[k]) begin
            w = words[k];
            push_word(w);
         end
         build_exp(all_w, bt);
         capture(exp_q.size());
         bad = first_wave_error(inv);
         checks++;
         if (bad >= 0) begin
            failures++;
            $display("FAIL random_wave iter %0d clock %0d out=%b busy=%b done=%b, expected out=%b busy=1 done=0",
                     iter, bad, cap_out[bad], cap_busy[bad], cap_done[bad], exp_q[bad] ^ inv);
         end
         n = exp_q.size();
         checks++;
         if (cap_done[n] !== 1'b1 || cap_busy[n] !== 1'b0 || cap_out[n] !== inv || cap_done[n+1] !== 1'b0) begin
            failures++;
            $display("FAIL random_done iter %0d done=%b busy=%b out=%b next_done=%b, expected 1 0 %b 0",
                     iter, cap_done[n], cap_busy[n], cap_out[n], cap_done[n+1], inv);
         end
         checks++;
         if (level !== '0) begin
            failures++;
            $display("FAIL random_level iter %0d level=%0d, expected 0", iter, level);
         end
      end
      line_invert = 1'b0;
   endtask

   task automatic test_full();
      logic [7:0] words[$];
      logic [7:0] w;
      int bad;
      int n;
      bit_time = 16'd1;
      line_invert = 1'b0;
      late_q.delete();
      for (int k = 0; k < DEPTH; k++) begin
         w = {3'($urandom_range(1, 5)), 5'($urandom)};
         words.push_back(w);
         push_word(w);
      end
      checks++;
      if (wr_ready !== 1'b0 || level !== FULL_LVL) begin
         failures++;
         $display("FAIL full_flags wr_ready=%b level=%0d, expected 0 %0d", wr_ready, level, DEPTH);
      end
      push_word(8'h20);
      checks++;
      if (level !== FULL_LVL) begin
         failures++;
         $display("FAIL full_refuse level=%0d, expected %0d", level, DEPTH);
      end
      build_exp(words, 1);
      n = exp_q.size();
      wr_valid = 1'b1;
      wr_data  = 8'h20;
      capture(n);
      bad = first_wave_error(1'b0);
      checks++;
      if (bad >= 0) begin
         failures++;
         $display("FAIL full_wave clock %0d out=%b busy=%b done=%b, expected out=%b busy=1 done=0",
                  bad, cap_out[bad], cap_busy[bad], cap_done[bad], exp_q[bad]);
      end
      checks++;
      if (cap_done[n] !== 1'b1 || cap_busy[n] !== 1'b0 || level !== '0) begin
         failures++;
         $display("FAIL full_done done=%b busy=%b level=%0d, expected 1 0 0", cap_done[n], cap_busy[n], level);
      end
   endtask

   task automatic test_abort();
      bit_time = 16'd5;
      line_invert = 1'b0;
      push_word(8'h21);
      push_word(8'h20);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (out !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL abort_premark out=%b busy=%b, expected 1 1", out, busy);
      end
      repeat (4) @(negedge clk);
      abort = 1'b1;
      wr_valid = 1'b1;
      wr_data = 8'h42;
      @(negedge clk);
      abort = 1'b0;
      wr_valid = 1'b0;
      checks++;
      if (out !== 1'b0 || busy !== 1'b0 || level !== '0 || done !== 1'b0) begin
         failures++;
         $display("FAIL abort_next out=%b busy=%b level=%0d done=%b, expected 0 0 0 0", out, busy, level, done);
      end
      @(negedge clk);
      checks++;
      if (out !== 1'b0 || busy !== 1'b0 || level !== '0 || done !== 1'b0) begin
         failures++;
         $display("FAIL abort_after out=%b busy=%b level=%0d done=%b, expected 0 0 0 0", out, busy, level, done);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL empty_start busy=%b done=%b, expected 0 0", busy, done);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || out !== 1'b0) begin
         failures++;
         $display("FAIL empty_start_after busy=%b done=%b out=%b, expected 0 0 0", busy, done, out);
      end
   endtask

   task automatic test_invert_reset();
      logic [7:0] wq[$];
      int bad;
      int lows;
      wq = '{8'h21, 8'h03};
      bit_time = '0;
      line_invert = 1'b1;
      late_q.delete();
      @(negedge clk);
      checks++;
      if (out !== 1'b1) begin
         failures++;
         $display("FAIL invert_idle out=%b, expected 1", out);
      end
      foreach (wq[k]) push_word(wq[k]);
      build_exp(wq, 0);
      capture(exp_q.size());
      bad = first_wave_error(1'b1);
      checks++;
      if (bad >= 0) begin
         failures++;
         $display("FAIL invert_wave clock %0d out=%b busy=%b done=%b, expected out=%b busy=1 done=0",
                  bad, cap_out[bad], cap_busy[bad], cap_done[bad], exp_q[bad] ^ 1'b1);
      end
      lows = 0;
      foreach (cap_out[i]) if (cap_out[i] === 1'b0) lows++;
      checks++;
      if (lows != 3) begin
         failures++;
         $display("FAIL invert_mark_len low clocks=%0d, expected 3", lows);
      end
      push_word(8'h21);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (out !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL invert_mark out=%b busy=%b, expected 0 1", out, busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out !== 1'b1 || busy !== 1'b0 || level !== '0 || done !== 1'b0) begin
         failures++;
         $display("FAIL async_reset out=%b busy=%b level=%0d done=%b, expected 1 0 0 0", out, busy, level, done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bad = -1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bad < 0 && (out !== 1'b1 || busy !== 1'b0 || done !== 1'b0)) bad = i;
      end
      checks++;
      if (bad >= 0) begin
         failures++;
         $display("FAIL post_reset_quiet clock %0d out=%b busy=%b done=%b, expected 1 0 0", bad, out, busy, done);
      end
   endtask

   initial begin
      test_reset();
      test_letter_e();
      test_sequence_a_t();
      test_random();
      test_full();
      test_abort();
      test_invert_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
